// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer: op codes, FSM states
// and fault codes.
package pc_seq_pkg;

  localparam logic [2:0] OP_INC  = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_JZ   = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PUSH  = 3'd1;
  localparam logic [2:0] ST_POP   = 3'd2;
  localparam logic [2:0] ST_LOAD  = 3'd3;
  localparam logic [2:0] ST_FAULT = 3'd4;

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_OVF  = 2'b01;
  localparam logic [1:0] ERR_UDF  = 2'b10;

endpackage

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address LIFO: RAM array with a registered read of the top entry
// (sp-1); only the occupancy counter is reset.
module ret_stack #(
  parameter int ADDR_W      = 8,
  parameter int STACK_DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [ADDR_W-1:0]              wdata,
  output logic [ADDR_W-1:0]              rdata,
  output logic [$clog2(STACK_DEPTH):0]   sp,
  output logic                           full,
  output logic                           empty
);

  localparam int IDX_W = $clog2(STACK_DEPTH);

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;

  assign wr_idx = sp[IDX_W-1:0];
  assign rd_idx = wr_idx - IDX_W'(1);
  assign full   = (sp == (IDX_W+1)'(STACK_DEPTH));
  assign empty  = (sp == '0);

  // Reading during the pop cycle delivers the popped entry one cycle later.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= wdata;
    end
    rdata <= mem[rd_idx];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + (IDX_W+1)'(1);
    end else if (pop && !empty) begin
      sp <= sp - (IDX_W+1)'(1);
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter controller: INC/JMP/JZ resolve in one cycle, CALL and RET
// sequence through the return stack, and stack faults stick until cleared.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                 ADDR_W       = 8,
  parameter int                 STACK_DEPTH  = 8,
  parameter logic [ADDR_W-1:0]  RESET_VECTOR = '0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          op_valid,
  output logic                          op_ready,
  input  logic [2:0]                    op_code,
  input  logic                          op_cond,
  input  logic [ADDR_W-1:0]             op_target,
  output logic [ADDR_W-1:0]             pc,
  output logic                          pc_valid,
  output logic [$clog2(STACK_DEPTH):0]  sp,
  output logic                          stack_full,
  output logic                          stack_empty,
  output logic                          err,
  output logic [1:0]                    err_code,
  input  logic                          err_clr
);

  logic [2:0]        state;
  logic [ADDR_W-1:0] target_lat;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] stack_rdata;
  logic              accept;

  assign pc_inc   = pc + ADDR_W'(1);
  // Ready is forced low while reset is held, not just after the first edge.
  assign op_ready = rst && (state == ST_IDLE);
  assign accept   = op_valid && op_ready;

  ret_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (state == ST_PUSH),
    .pop   (state == ST_POP),
    .wdata (pc_inc),
    .rdata (stack_rdata),
    .sp    (sp),
    .full  (stack_full),
    .empty (stack_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      pc         <= RESET_VECTOR;
      pc_valid   <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      target_lat <= '0;
    end else begin
      pc_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            case (op_code)
              OP_INC: begin
                pc       <= pc_inc;
                pc_valid <= 1'b1;
              end
              OP_JMP: begin
                pc       <= op_target;
                pc_valid <= 1'b1;
              end
              OP_JZ: begin
                pc       <= op_cond ? op_target : pc_inc;
                pc_valid <= 1'b1;
              end
              OP_CALL: begin
                if (stack_full) begin
                  err      <= 1'b1;
                  err_code <= ERR_OVF;
                  state    <= ST_FAULT;
                end else begin
                  target_lat <= op_target;
                  state      <= ST_PUSH;
                end
              end
              OP_RET: begin
                if (stack_empty) begin
                  err      <= 1'b1;
                  err_code <= ERR_UDF;
                  state    <= ST_FAULT;
                end else begin
                  state <= ST_POP;
                end
              end
              default: begin
                pc       <= pc_inc;
                pc_valid <= 1'b1;
              end
            endcase
          end
        end
        ST_PUSH: begin
          pc       <= target_lat;
          pc_valid <= 1'b1;
          state    <= ST_IDLE;
        end
        ST_POP: begin
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          pc       <= stack_rdata;
          pc_valid <= 1'b1;
          state    <= ST_IDLE;
        end
        ST_FAULT: begin
          if (err_clr) begin
            err      <= 1'b0;
            err_code <= ERR_NONE;
            state    <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: straight-line steps with hand-computed
// expectations, sampled 1ns after each rising edge.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [2:0] op_code = 3'd0;
  logic       op_cond = 1'b0;
  logic [7:0] op_target = 8'h00;
  logic [7:0] pc;
  logic       pc_valid;
  logic [3:0] sp;
  logic       stack_full;
  logic       stack_empty;
  logic       err;
  logic [1:0] err_code;
  logic       err_clr = 1'b0;

  int compared = 0;
  int mismatched = 0;

  pc_sequencer #(
    .ADDR_W       (8),
    .STACK_DEPTH  (8),
    .RESET_VECTOR (8'h00)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .op_valid    (op_valid),
    .op_ready    (op_ready),
    .op_code     (op_code),
    .op_cond     (op_cond),
    .op_target   (op_target),
    .pc          (pc),
    .pc_valid    (pc_valid),
    .sp          (sp),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .err         (err),
    .err_code    (err_code),
    .err_clr     (err_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one op for a single accept edge, then withdraw it.
  task automatic do_op(input logic [2:0] code, input logic cond, input logic [7:0] tgt);
    op_valid  = 1'b1;
    op_code   = code;
    op_cond   = cond;
    op_target = tgt;
    tick();
    op_valid  = 1'b0;
    $display("op code=%0d cond=%0d target=0x%02h -> pc=0x%02h sp=%0d ready=%0b err=%0b",
             code, cond, tgt, pc, sp, op_ready, err);
  endtask

  task automatic call_full(input logic [7:0] tgt, input logic [7:0] exp_pc, input logic [3:0] exp_sp);
    do_op(3'd3, 1'b0, tgt);
    chk("call_ready_low", op_ready, 0);
    chk("call_no_early_valid", pc_valid, 0);
    tick();
    chk("call_pc", pc, exp_pc);
    chk("call_sp", sp, exp_sp);
    chk("call_valid", pc_valid, 1);
  endtask

  task automatic ret_full(input logic [7:0] exp_pc, input logic [3:0] exp_sp);
    do_op(3'd4, 1'b0, 8'h00);
    chk("ret_pop_ready", op_ready, 0);
    tick();
    chk("ret_load_valid", pc_valid, 0);
    tick();
    chk("ret_pc", pc, exp_pc);
    chk("ret_sp", sp, exp_sp);
    chk("ret_valid", pc_valid, 1);
  endtask

  initial begin
    // Reset state while rst is held low.
    #2;
    chk("rst_pc", pc, 8'h00);
    chk("rst_sp", sp, 0);
    chk("rst_ready", op_ready, 0);
    chk("rst_pc_valid", pc_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_empty", stack_empty, 1);
    tick();
    rst = 1'b1;
    #1;
    chk("post_rst_ready", op_ready, 1);

    // Three back-to-back INCs with valid held high.
    op_valid = 1'b1;
    op_code  = 3'd0;
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("inc_pc", pc, i);
      chk("inc_valid", pc_valid, 1);
      chk("inc_ready", op_ready, 1);
      $display("inc step %0d pc=0x%02h", i, pc);
    end
    op_valid = 1'b0;
    tick();
    chk("inc_valid_drop", pc_valid, 0);
    chk("inc_pc_hold", pc, 8'h03);

    // Reserved op code behaves as INC.
    do_op(3'd6, 1'b0, 8'hAA);
    chk("reserved_inc", pc, 8'h04);

    // JZ both ways.
    do_op(3'd1, 1'b0, 8'h10);
    chk("jmp_pc", pc, 8'h10);
    chk("jmp_valid", pc_valid, 1);
    do_op(3'd2, 1'b0, 8'h40);
    chk("jz0_pc", pc, 8'h11);
    chk("jz0_valid", pc_valid, 1);
    do_op(3'd2, 1'b1, 8'h40);
    chk("jz1_pc", pc, 8'h40);
    chk("jz1_valid", pc_valid, 1);

    // CALL/RET pair from 0x20.
    do_op(3'd1, 1'b0, 8'h20);
    call_full(8'h80, 8'h80, 4'd1);
    ret_full(8'h21, 4'd0);
    tick();
    chk("ret_valid_single", pc_valid, 0);

    // Return address wraps from 0xFF to 0x00.
    do_op(3'd1, 1'b0, 8'hFF);
    call_full(8'h05, 8'h05, 4'd1);
    ret_full(8'h00, 4'd0);

    // err_clr outside FAULT is ignored.
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_idle_err", err, 0);
    chk("clr_idle_ready", op_ready, 1);

    // Eight nested CALLs from 0x00: each pushes pc+1, lands on 0x10*(i+1).
    for (int i = 0; i < 8; i++) begin
      call_full(8'((i + 1) * 16), 8'((i + 1) * 16), 4'(i + 1));
    end
    chk("nest_full", stack_full, 1);

    // Ninth CALL overflows.
    do_op(3'd3, 1'b0, 8'h99);
    chk("ovf_err", err, 1);
    chk("ovf_code", err_code, 2'b01);
    chk("ovf_sp", sp, 8);
    chk("ovf_pc", pc, 8'h80);
    chk("ovf_ready", op_ready, 0);
    chk("ovf_no_valid", pc_valid, 0);
    tick();
    chk("fault_hold_err", err, 1);
    chk("fault_hold_pc", pc, 8'h80);

    // Clear with a concurrent op request that must not be taken.
    err_clr   = 1'b1;
    op_valid  = 1'b1;
    op_code   = 3'd0;
    tick();
    err_clr  = 1'b0;
    op_valid = 1'b0;
    chk("clr_err", err, 0);
    chk("clr_code", err_code, 0);
    chk("clr_ready", op_ready, 1);
    chk("clr_pc_frozen", pc, 8'h80);
    chk("clr_no_valid", pc_valid, 0);

    // Unwind in LIFO order: return addresses 0x71, 0x61, ... 0x01.
    for (int i = 7; i >= 0; i--) begin
      ret_full(8'(i * 16 + 1), 4'(i));
    end
    chk("unwind_empty", stack_empty, 1);

    // Ninth RET underflows.
    do_op(3'd4, 1'b0, 8'h00);
    chk("udf_err", err, 1);
    chk("udf_code", err_code, 2'b10);
    chk("udf_sp", sp, 0);
    chk("udf_pc", pc, 8'h01);
    chk("udf_ready", op_ready, 0);
    chk("udf_no_valid", pc_valid, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("udf_clr_ready", op_ready, 1);

    // Reset during POP after CALL from 0x30.
    do_op(3'd1, 1'b0, 8'h30);
    call_full(8'h50, 8'h50, 4'd1);
    do_op(3'd4, 1'b0, 8'h00);
    chk("pop_ready_low", op_ready, 0);
    rst = 1'b0;
    #1;
    chk("abort_pc", pc, 8'h00);
    chk("abort_sp", sp, 0);
    chk("abort_ready", op_ready, 0);
    chk("abort_valid", pc_valid, 0);
    tick();
    chk("abort_hold_pc", pc, 8'h00);
    rst = 1'b1;
    tick();
    chk("resume_no_valid", pc_valid, 0);
    chk("resume_pc", pc, 8'h00);
    chk("resume_ready", op_ready, 1);
    do_op(3'd0, 1'b0, 8'h00);
    chk("resume_inc_pc", pc, 8'h01);
    chk("resume_inc_valid", pc_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
